// File: rtl/layer_mux_pkg.sv
// Shared types and constants for the layer priority compositor.
// Holds the alert FSM state type and the default colour encoding.
package layer_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ALERT = 1'b1
    } alert_state_t;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam int         RGB_W_DEF            = 8;

endpackage

// File: rtl/layer_priority_mux_blink.sv
// Alert blink controller: frame-synchronous FSM with frame and phase counters.
// blinkOn only changes on startOfFrame so a frame is never torn mid-scan.
module blink_controller
    import layer_mux_pkg::*;
#(
    parameter int BLINK_FRAMES = 15,
    parameter int ALERT_FRAMES = 180
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic alertStart,
    output logic alertActive,
    output logic blinkOn
);

    localparam int FW = (ALERT_FRAMES > 1) ? $clog2(ALERT_FRAMES) : 1;
    localparam int PW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    alert_state_t    state_q, state_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]   phase_cnt_q, phase_cnt_d;
    logic            blink_on_q, blink_on_d;

    // Next-state: alertStart (re)arms and beats any frame tick in the same cycle.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        blink_on_d  = blink_on_q;
        if (alertStart) begin
            state_d     = ALERT;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (state_q == ALERT && startOfFrame) begin
            if (frame_cnt_q == FW'(ALERT_FRAMES - 1)) begin
                state_d     = IDLE;
                frame_cnt_d = '0;
                phase_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (phase_cnt_q == PW'(BLINK_FRAMES - 1)) begin
                    phase_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign alertActive = (state_q == ALERT);
    assign blinkOn     = blink_on_q;

endmodule

// File: rtl/layer_priority_mux.sv
// N-channel priority compositor for VGA overlays; channel 0 wins.
// Optional collision outputs under macro LAYER_MUX_COLLISION_EN.
module layer_priority_mux
    import layer_mux_pkg::*;
#(
    parameter int               NUM_CH       = 8,
    parameter int               RGB_W        = RGB_W_DEF,
    parameter logic [RGB_W-1:0] TRANSPARENT  = TRANSPARENT_ENCODING,
    parameter int               BLINK_FRAMES = 15,
    parameter int               ALERT_FRAMES = 180,
    localparam int              CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUM_CH-1:0]            drawReq,
    input  logic [NUM_CH-1:0][RGB_W-1:0] rgbIn,
    input  logic [NUM_CH-1:0]            chEnable,
    input  logic [NUM_CH-1:0]            blinkMask,
    input  logic                         alertStart,
`ifdef LAYER_MUX_COLLISION_EN
    output logic                         collision,
    output logic                         collisionFrame,
`endif
    output logic                         drawingRequest,
    output logic [RGB_W-1:0]             RGBout,
    output logic [CW-1:0]                activeCh,
    output logic                         alertActive
);

    logic              blink_on;
    logic [NUM_CH-1:0] valid;
    logic              draw_q, draw_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic [CW-1:0]     ch_q, ch_d;

    blink_controller #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .ALERT_FRAMES (ALERT_FRAMES)
    ) u_blink (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .alertStart   (alertStart),
        .alertActive  (alertActive),
        .blinkOn      (blink_on)
    );

    // Per-channel visibility: enabled, opaque, and not blanked by the alert.
    always_comb begin
        valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            valid[i] = drawReq[i] & chEnable[i]
                     & (rgbIn[i] != TRANSPARENT)
                     & ~(blinkMask[i] & alertActive & ~blink_on);
        end
    end

    // Priority encoder: scan downward so the lowest valid index is kept.
    always_comb begin
        draw_d = 1'b0;
        rgb_d  = TRANSPARENT;
        ch_d   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i]) begin
                draw_d = 1'b1;
                rgb_d  = rgbIn[i];
                ch_d   = CW'(i);
            end
        end
    end

    // Output registers; all three move together on one edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_q <= 1'b0;
            rgb_q  <= '0;
            ch_q   <= '0;
        end else begin
            draw_q <= draw_d;
            rgb_q  <= rgb_d;
            ch_q   <= ch_d;
        end
    end

    assign drawingRequest = draw_q;
    assign RGBout         = rgb_q;
    assign activeCh       = ch_q;

`ifdef LAYER_MUX_COLLISION_EN
    logic coll_q, coll_d;
    logic coll_frame_q, coll_frame_d;

    // Two or more valid channels: clearing the lowest set bit leaves something.
    always_comb begin
        coll_d       = |(valid & (valid - NUM_CH'(1)));
        coll_frame_d = coll_frame_q;
        if (startOfFrame)
            coll_frame_d = 1'b0;
        if (coll_d)
            coll_frame_d = 1'b1;
    end

    // Collision registers, aligned with drawingRequest.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_q       <= 1'b0;
            coll_frame_q <= 1'b0;
        end else begin
            coll_q       <= coll_d;
            coll_frame_q <= coll_frame_d;
        end
    end

    assign collision      = coll_q;
    assign collisionFrame = coll_frame_q;
`endif

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux with a queue scoreboard.
// Collision checks compile only with LAYER_MUX_COLLISION_EN.
module tb_layer_priority_mux;

    localparam int BF = 15;
    localparam int AF = 180;

    logic            clk;
    logic            resetN;
    logic            startOfFrame;
    logic [7:0]      drawReq;
    logic [7:0][7:0] rgbIn;
    logic [7:0]      chEnable;
    logic [7:0]      blinkMask;
    logic            alertStart;
    logic            drawingRequest;
    logic [7:0]      RGBout;
    logic [2:0]      activeCh;
    logic            alertActive;
`ifdef LAYER_MUX_COLLISION_EN
    logic            collision;
    logic            collisionFrame;
`endif

    typedef struct {
        logic       dr;
        logic [7:0] rgb;
        logic [2:0] ch;
        logic       aa;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    layer_priority_mux dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .drawReq        (drawReq),
        .rgbIn          (rgbIn),
        .chEnable       (chEnable),
        .blinkMask      (blinkMask),
        .alertStart     (alertStart),
`ifdef LAYER_MUX_COLLISION_EN
        .collision      (collision),
        .collisionFrame (collisionFrame),
`endif
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .activeCh       (activeCh),
        .alertActive    (alertActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit vis(int k);
        return (k >= AF) || (((k / BF) % 2) == 0);
    endfunction

    task automatic push(logic dr, logic [7:0] rgb, logic [2:0] ch, logic aa);
        exp_t e;
        e.dr  = dr;
        e.rgb = rgb;
        e.ch  = ch;
        e.aa  = aa;
        sb.push_back(e);
    endtask

    task automatic check(string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed dr=%0b", tag, drawingRequest);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (drawingRequest === e.dr) else begin
                errors++;
                $error("FAIL %s dr: observed %0b expected %0b", tag, drawingRequest, e.dr);
            end
            checks++;
            assert (RGBout === e.rgb) else begin
                errors++;
                $error("FAIL %s rgb: observed %h expected %h", tag, RGBout, e.rgb);
            end
            checks++;
            assert (activeCh === e.ch) else begin
                errors++;
                $error("FAIL %s ch: observed %0d expected %0d", tag, activeCh, e.ch);
            end
            checks++;
            assert (alertActive === e.aa) else begin
                errors++;
                $error("FAIL %s aa: observed %0b expected %0b", tag, alertActive, e.aa);
            end
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Start-of-frame cycle (no pixel), then one ch1 pixel of frame k.
    task automatic frame(int k);
        bit aa;
        bit v;
        aa = (k < AF);
        v  = vis(k);
        startOfFrame = 1'b1;
        drawReq      = 8'h00;
        push(1'b0, 8'hFF, 3'd0, aa);
        tick("sof");
        startOfFrame = 1'b0;
        drawReq      = 8'h02;
        push(v, v ? 8'h40 : 8'hFF, v ? 3'd1 : 3'd0, aa);
        tick($sformatf("frame%0d", k));
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        drawReq      = '0;
        rgbIn        = '0;
        chEnable     = '1;
        blinkMask    = '0;
        alertStart   = 1'b0;

        push(1'b0, 8'h00, 3'd0, 1'b0);
        tick("reset0");
        drawReq  = 8'h04;
        rgbIn[2] = 8'h1C;
        push(1'b0, 8'h00, 3'd0, 1'b0);
        tick("reset1");
        resetN = 1'b1;

        drawReq  = 8'h24;
        rgbIn[5] = 8'hE0;
        push(1'b1, 8'h1C, 3'd2, 1'b0);
        tick("ch2_over_ch5");

        drawReq  = 8'h09;
        rgbIn[0] = 8'hFF;
        rgbIn[3] = 8'h03;
        push(1'b1, 8'h03, 3'd3, 1'b0);
        tick("transp_fall");

        chEnable[3] = 1'b0;
        push(1'b0, 8'hFF, 3'd0, 1'b0);
        tick("ch3_disabled");
        chEnable = '1;

        drawReq  = 8'h80;
        rgbIn[7] = 8'h55;
        push(1'b1, 8'h55, 3'd7, 1'b0);
        tick("ch7_only");

        drawReq = 8'h00;
        push(1'b0, 8'hFF, 3'd0, 1'b0);
        tick("none");

        // Blink over a full alert.
        rgbIn[1]   = 8'h40;
        blinkMask  = 8'h02;
        drawReq    = 8'h02;
        alertStart = 1'b1;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("alert_start");
        alertStart = 1'b0;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("frame0");
        for (int k = 1; k <= AF; k++) frame(k);
        push(1'b1, 8'h40, 3'd1, 1'b0);
        tick("post_alert");

        // Restart at frame 100.
        alertStart = 1'b1;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("alert2_start");
        alertStart = 1'b0;
        for (int k = 1; k <= 100; k++) frame(k);
        alertStart = 1'b1;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("restart100");
        alertStart = 1'b0;
        for (int k = 1; k <= AF; k++) frame(k);

        // Restart coincident with startOfFrame during a blank phase.
        alertStart = 1'b1;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("alert3_start");
        alertStart = 1'b0;
        for (int k = 1; k <= 20; k++) frame(k);
        alertStart   = 1'b1;
        startOfFrame = 1'b1;
        drawReq      = 8'h00;
        push(1'b0, 8'hFF, 3'd0, 1'b1);
        tick("coincident");
        alertStart   = 1'b0;
        startOfFrame = 1'b0;
        checks++;
        assert (dut.u_blink.frame_cnt_q === 8'd0) else begin
            errors++;
            $error("FAIL coinc_fcnt: observed %0d expected 0", dut.u_blink.frame_cnt_q);
        end
        drawReq = 8'h02;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("coinc_frame0");
        for (int k = 1; k <= AF; k++) frame(k);

        // Asynchronous reset during a blank phase with DR high.
        alertStart = 1'b1;
        push(1'b1, 8'h40, 3'd1, 1'b1);
        tick("alert4_start");
        alertStart = 1'b0;
        for (int k = 1; k <= 15; k++) frame(k);
        rgbIn[0] = 8'h33;
        drawReq  = 8'h03;
        push(1'b1, 8'h33, 3'd0, 1'b1);
        tick("pre_reset");
        #2;
        resetN = 1'b0;
        #1;
        push(1'b0, 8'h00, 3'd0, 1'b0);
        check("async_reset");
        checks++;
        assert (dut.u_blink.blink_on_q === 1'b1) else begin
            errors++;
            $error("FAIL rst_blink: observed %0b expected 1", dut.u_blink.blink_on_q);
        end
        #3;
        resetN  = 1'b1;
        drawReq = 8'h02;
        push(1'b1, 8'h40, 3'd1, 1'b0);
        tick("post_reset");

`ifdef LAYER_MUX_COLLISION_EN
        rgbIn[4] = 8'h12;
        drawReq  = 8'h11;
        push(1'b1, 8'h33, 3'd0, 1'b0);
        tick("coll_pix");
        checks++;
        assert (collision === 1'b1 && collisionFrame === 1'b1) else begin
            errors++;
            $error("FAIL coll_set: observed %0b%0b expected 11", collision, collisionFrame);
        end
        drawReq = 8'h01;
        push(1'b1, 8'h33, 3'd0, 1'b0);
        tick("coll_one");
        checks++;
        assert (collision === 1'b0 && collisionFrame === 1'b1) else begin
            errors++;
            $error("FAIL coll_hold: observed %0b%0b expected 01", collision, collisionFrame);
        end
        drawReq      = 8'h11;
        startOfFrame = 1'b1;
        push(1'b1, 8'h33, 3'd0, 1'b0);
        tick("coll_sof_set");
        checks++;
        assert (collisionFrame === 1'b1) else begin
            errors++;
            $error("FAIL coll_setwins: observed %0b expected 1", collisionFrame);
        end
        drawReq = 8'h00;
        push(1'b0, 8'hFF, 3'd0, 1'b0);
        tick("coll_sof_clr");
        checks++;
        assert (collision === 1'b0 && collisionFrame === 1'b0) else begin
            errors++;
            $error("FAIL coll_clr: observed %0b%0b expected 00", collision, collisionFrame);
        end
        startOfFrame = 1'b0;
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
